// File: rtl/loom_axil_master.sv
// Single-outstanding AXI-Lite initiator: valid/ready command port in, AXI-Lite
// read/write transactions out, with a response timeout guarding against dead slaves.
module loom_axil_master #(
  parameter int unsigned ADDR_WIDTH     = 20,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  input  logic [3:0]            req_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic [1:0]            rsp_resp_o,
  output logic                  rsp_timeout_o,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr_o,
  output logic                  m_axil_arvalid_o,
  input  logic                  m_axil_arready_i,
  input  logic [31:0]           m_axil_rdata_i,
  input  logic [1:0]            m_axil_rresp_i,
  input  logic                  m_axil_rvalid_i,
  output logic                  m_axil_rready_o,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr_o,
  output logic                  m_axil_awvalid_o,
  input  logic                  m_axil_awready_i,
  output logic [31:0]           m_axil_wdata_o,
  output logic [3:0]            m_axil_wstrb_o,
  output logic                  m_axil_wvalid_o,
  input  logic                  m_axil_wready_i,
  input  logic [1:0]            m_axil_bresp_i,
  input  logic                  m_axil_bvalid_i,
  output logic                  m_axil_bready_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t        state;
  logic          stale_rd;
  logic          stale_wr;
  logic [CW-1:0] to_cnt;

  logic stale_left;
  logic to_expired;
  logic aw_ok;
  logic w_ok;

  // Stale flags still pending after this cycle (a late response clears its flag now).
  assign stale_left = (stale_rd && !m_axil_rvalid_i) || (stale_wr && !m_axil_bvalid_i);
  assign to_expired = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);
  assign aw_ok      = !m_axil_awvalid_o || m_axil_awready_i;
  assign w_ok       = !m_axil_wvalid_o  || m_axil_wready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      stale_rd         <= 1'b0;
      stale_wr         <= 1'b0;
      to_cnt           <= '0;
      req_ready_o      <= 1'b0;
      rsp_valid_o      <= 1'b0;
      rsp_rdata_o      <= '0;
      rsp_resp_o       <= '0;
      rsp_timeout_o    <= 1'b0;
      busy_o           <= 1'b0;
      m_axil_araddr_o  <= '0;
      m_axil_arvalid_o <= 1'b0;
      m_axil_rready_o  <= 1'b0;
      m_axil_awaddr_o  <= '0;
      m_axil_awvalid_o <= 1'b0;
      m_axil_wdata_o   <= '0;
      m_axil_wstrb_o   <= '0;
      m_axil_wvalid_o  <= 1'b0;
      m_axil_bready_o  <= 1'b0;
    end else begin
      // Stale flags are only ever set while the FSM sits in RSP or IDLE.
      if (stale_rd && m_axil_rvalid_i) begin
        stale_rd        <= 1'b0;
        m_axil_rready_o <= 1'b0;
      end
      if (stale_wr && m_axil_bvalid_i) begin
        stale_wr        <= 1'b0;
        m_axil_bready_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if (req_write_i) begin
              m_axil_awaddr_o  <= req_addr_i;
              m_axil_wdata_o   <= req_wdata_i;
              m_axil_wstrb_o   <= req_wstrb_i;
              m_axil_awvalid_o <= 1'b1;
              m_axil_wvalid_o  <= 1'b1;
              state            <= WR_ADDR;
            end else begin
              m_axil_araddr_o  <= req_addr_i;
              m_axil_arvalid_o <= 1'b1;
              state            <= RD_ADDR;
            end
          end else begin
            req_ready_o <= !stale_left;
            busy_o      <= stale_left;
          end
        end

        RD_ADDR: begin
          if (m_axil_arready_i) begin
            m_axil_arvalid_o <= 1'b0;
            m_axil_rready_o  <= 1'b1;
            to_cnt           <= '0;
            state            <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (m_axil_rvalid_i) begin
            m_axil_rready_o <= 1'b0;
            rsp_rdata_o     <= m_axil_rdata_i;
            rsp_resp_o      <= m_axil_rresp_i;
            rsp_timeout_o   <= 1'b0;
            rsp_valid_o     <= 1'b1;
            state           <= RSP;
          end else if (to_expired) begin
            // rready stays high so the late beat can be absorbed.
            rsp_rdata_o   <= '0;
            rsp_resp_o    <= 2'b10;
            rsp_timeout_o <= 1'b1;
            rsp_valid_o   <= 1'b1;
            stale_rd      <= 1'b1;
            state         <= RSP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        WR_ADDR: begin
          if (m_axil_awvalid_o && m_axil_awready_i) m_axil_awvalid_o <= 1'b0;
          if (m_axil_wvalid_o && m_axil_wready_i)   m_axil_wvalid_o  <= 1'b0;
          if (aw_ok && w_ok) begin
            m_axil_bready_o <= 1'b1;
            to_cnt          <= '0;
            state           <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (m_axil_bvalid_i) begin
            m_axil_bready_o <= 1'b0;
            rsp_rdata_o     <= '0;
            rsp_resp_o      <= m_axil_bresp_i;
            rsp_timeout_o   <= 1'b0;
            rsp_valid_o     <= 1'b1;
            state           <= RSP;
          end else if (to_expired) begin
            rsp_rdata_o   <= '0;
            rsp_resp_o    <= 2'b10;
            rsp_timeout_o <= 1'b1;
            rsp_valid_o   <= 1'b1;
            stale_wr      <= 1'b1;
            state         <= RSP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= !stale_left;
            busy_o      <= stale_left;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_loom_axil_master.sv
// Bench for loom_axil_master: delay-configurable AXI-Lite slave model plus
// transaction-level expectations for data, response code, timeout and latency.
module tb_loom_axil_master;

  localparam int unsigned AW = 20;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;
  logic          rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] araddr, awaddr;
  logic          arvalid, arready, rvalid, rready;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0]   rdata, wdata;
  logic [1:0]    rresp, bresp;
  logic [3:0]    wstrb;

  loom_axil_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_resp_o(rsp_resp), .rsp_timeout_o(rsp_timeout), .busy_o(busy),
    .m_axil_araddr_o(araddr), .m_axil_arvalid_o(arvalid), .m_axil_arready_i(arready),
    .m_axil_rdata_i(rdata), .m_axil_rresp_i(rresp), .m_axil_rvalid_i(rvalid),
    .m_axil_rready_o(rready),
    .m_axil_awaddr_o(awaddr), .m_axil_awvalid_o(awvalid), .m_axil_awready_i(awready),
    .m_axil_wdata_o(wdata), .m_axil_wstrb_o(wstrb), .m_axil_wvalid_o(wvalid),
    .m_axil_wready_i(wready), .m_axil_bresp_i(bresp), .m_axil_bvalid_i(bvalid),
    .m_axil_bready_o(bready)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave configuration for the current transaction (cycles of delay per channel).
  int unsigned cfg_ar = 0, cfg_r = 0, cfg_aw = 0, cfg_w = 0, cfg_b = 0;
  logic [31:0] cfg_rdata = '0;
  logic [1:0]  cfg_rresp = '0, cfg_bresp = '0;

  int unsigned ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
  logic r_pend, b_pend, aw_seen, w_seen;
  logic [AW-1:0] ar_addr_seen, aw_addr_seen;
  logic [31:0]   wdata_seen;
  logic [3:0]    wstrb_seen;
  logic awhs, whs;

  assign arready = arvalid && (ar_cnt >= cfg_ar);
  assign awready = awvalid && (aw_cnt >= cfg_aw);
  assign wready  = wvalid  && (w_cnt  >= cfg_w);
  assign rvalid  = r_pend && (r_cnt >= cfg_r);
  assign bvalid  = b_pend && (b_cnt >= cfg_b);
  assign rdata   = cfg_rdata;
  assign rresp   = cfg_rresp;
  assign bresp   = cfg_bresp;
  assign awhs    = awvalid && awready;
  assign whs     = wvalid && wready;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0; b_cnt <= 0;
      r_pend <= 1'b0; b_pend <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
    end else begin
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid  && !wready)  ? w_cnt + 1  : 0;
      if (arvalid && arready) begin
        r_pend <= 1'b1; r_cnt <= 0; ar_addr_seen <= araddr;
      end else if (r_pend) begin
        if (rvalid && rready) r_pend <= 1'b0;
        else r_cnt <= r_cnt + 1;
      end
      if (awhs) begin aw_seen <= 1'b1; aw_addr_seen <= awaddr; end
      if (whs)  begin w_seen <= 1'b1; wdata_seen <= wdata; wstrb_seen <= wstrb; end
      if ((aw_seen || awhs) && (w_seen || whs)) begin
        b_pend <= 1'b1; b_cnt <= 0; aw_seen <= 1'b0; w_seen <= 1'b0;
      end else if (b_pend) begin
        if (bvalid && bready) b_pend <= 1'b0;
        else b_cnt <= b_cnt + 1;
      end
    end
  end

  // AXI rule: a valid without handshake must stay up with a stable payload.
  logic p_ar, p_aw, p_w;
  logic [AW-1:0] p_araddr, p_awaddr;
  logic [31:0] p_wdata;
  always @(negedge clk) begin
    if (rst) begin
      p_ar = 1'b0; p_aw = 1'b0; p_w = 1'b0;
    end else begin
      if (p_ar) chk("ar_stable", {arvalid, araddr}, {1'b1, p_araddr});
      if (p_aw) chk("aw_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_w)  chk("w_stable",  {wvalid, wdata},   {1'b1, p_wdata});
      p_ar = arvalid && !arready; p_araddr = araddr;
      p_aw = awvalid && !awready; p_awaddr = awaddr;
      p_w  = wvalid && !wready;   p_wdata  = wdata;
    end
  end

  int acc_cyc;

  // Present a request; returns at the negedge of the cycle after acceptance.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    int n;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    chk("req_ready_wait", req_ready, 1'b1);
    acc_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;
  endtask

  // Wait for and check the response against the transaction-level expectation.
  task automatic finish(input string tag, input logic wr, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [3:0] s, input int unsigned hold);
    int n, lat, dly, base;
    logic exp_to;
    logic [31:0] exp_rd;
    logic [1:0]  exp_rs;
    logic [34:0] snap;
    dly    = wr ? cfg_b : cfg_r;
    base   = wr ? ((cfg_aw > cfg_w) ? cfg_aw : cfg_w) : cfg_ar;
    exp_to = (dly >= TO);
    lat    = 3 + base + (exp_to ? TO - 1 : dly);
    exp_rd = (wr || exp_to) ? 32'h0 : cfg_rdata;
    exp_rs = exp_to ? 2'b10 : (wr ? cfg_bresp : cfg_rresp);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk({tag, ".rsp_valid"}, rsp_valid, 1'b1);
    chk({tag, ".latency"}, cyc - acc_cyc, lat);
    chk({tag, ".rdata"}, rsp_rdata, exp_rd);
    chk({tag, ".resp"}, rsp_resp, exp_rs);
    chk({tag, ".timeout"}, rsp_timeout, exp_to);
    if (wr) chk({tag, ".wr_phase"}, {aw_addr_seen, wdata_seen, wstrb_seen}, {a, d, s});
    else    chk({tag, ".rd_phase"}, ar_addr_seen, a);
    snap = {rsp_rdata, rsp_resp, rsp_timeout};
    repeat (hold) @(negedge clk);
    if (hold != 0)
      chk({tag, ".hold"}, {rsp_valid, req_ready, rsp_rdata, rsp_resp, rsp_timeout},
          {1'b1, 1'b0, snap});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".rsp_drop"}, rsp_valid, 1'b0);
  endtask

  task automatic txn(input string tag, input logic wr, input logic [AW-1:0] a,
                     input logic [31:0] d, input logic [3:0] s, input int unsigned hold);
    issue(wr, a, d, s);
    finish(tag, wr, a, d, s, hold);
  endtask

  function automatic logic [127:0] all_outs();
    return {req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, busy, arvalid, araddr,
            rready, awvalid, awaddr, wvalid, wdata, wstrb, bready};
  endfunction

  initial begin
    int unsigned n;
    logic wr;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 128'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {req_ready, busy}, 2'b10);

    // Read with arready in cycle 1 and rvalid in cycle 3.
    cfg_ar = 0; cfg_r = 1; cfg_rdata = 32'hCAFEF00D; cfg_rresp = 2'b00;
    txn("rd_basic", 1'b0, 20'h00104, 32'h0, 4'h0, 0);

    // Write: awready cycle 1, wready cycle 3.
    cfg_aw = 0; cfg_w = 2; cfg_b = 0; cfg_bresp = 2'b00;
    issue(1'b1, 20'h00010, 32'h1, 4'hF);
    chk("wr_c1", {awvalid, wvalid, bready}, 3'b110);
    @(negedge clk);
    chk("wr_c2", {awvalid, wvalid, bready}, 3'b010);
    @(negedge clk);
    chk("wr_c3", {awvalid, wvalid, bready}, 3'b010);
    @(negedge clk);
    chk("wr_c4", {awvalid, wvalid, bready}, 3'b001);
    finish("wr_split", 1'b1, 20'h00010, 32'h1, 4'hF, 0);

    cfg_aw = 1; cfg_w = 1;
    txn("wr_same", 1'b1, 20'h00020, 32'h12345678, 4'h3, 0);
    cfg_aw = 2; cfg_w = 0;
    txn("wr_w_first", 1'b1, 20'h00024, 32'h0BADBEEF, 4'hC, 0);

    // Response held off for 5 cycles.
    cfg_ar = 1; cfg_r = 0; cfg_rdata = 32'h55AA33CC; cfg_rresp = 2'b01;
    txn("rd_hold", 1'b0, 20'hFFFFC, 32'h0, 4'h0, 5);

    cfg_aw = 0; cfg_w = 0; cfg_b = 2; cfg_bresp = 2'b10;
    txn("wr_slverr", 1'b1, 20'h00030, 32'hA5A5A5A5, 4'hF, 0);

    // Boundary: rvalid on the last waiting cycle beats the timeout.
    cfg_ar = 0; cfg_r = TO - 1; cfg_rdata = 32'h13579BDF; cfg_rresp = 2'b00;
    txn("rd_edge", 1'b0, 20'h00200, 32'h0, 4'h0, 0);

    // Read timeout with the late beat arriving well after the error response.
    cfg_r = TO + 8;
    txn("rd_timeout", 1'b0, 20'h00300, 32'h0, 4'h0, 0);
    chk("stale_hold", {req_ready, rready, busy}, 3'b011);
    n = 0;
    while (!req_ready && n < 60) begin @(negedge clk); n++; end
    chk("stale_clear", {req_ready, rready, busy}, 3'b100);

    cfg_b = TO + 3; cfg_bresp = 2'b00;
    txn("wr_timeout", 1'b1, 20'h00304, 32'h77, 4'h1, 1);

    // Reset while waiting for bvalid abandons the write.
    cfg_aw = 0; cfg_w = 0; cfg_b = 40;
    issue(1'b1, 20'h00400, 32'hDEAD0001, 4'hF);
    repeat (3) @(negedge clk);
    chk("pre_rst_wr_resp", {bready, busy}, 2'b11);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", all_outs(), 128'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cfg_b = 0; cfg_bresp = 2'b01;
    txn("after_rst", 1'b1, 20'h00404, 32'hFEEDFACE, 4'h6, 0);

    // Randomized mix of reads/writes, delays, error codes and timeouts.
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom);
      cfg_ar = $urandom_range(0, 3); cfg_aw = $urandom_range(0, 3);
      cfg_w = $urandom_range(0, 3);
      cfg_r = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 8) : $urandom_range(0, 4);
      cfg_b = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 8) : $urandom_range(0, 4);
      cfg_rdata = $urandom; cfg_rresp = 2'($urandom); cfg_bresp = 2'($urandom);
      txn(wr ? "rnd_wr" : "rnd_rd", wr, AW'($urandom), $urandom, 4'($urandom),
          $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
